// File: rtl/vga_sync_decoder.sv
`timescale 1ns / 1ps
// vga_sync_decoder
// Recovers pixel timing from an active-low hsync/vsync pair sampled with a
// pixel strobe: pixel coordinates relative to the active window, an
// active-video flag, lock status, line count of the last frame, and
// frame-start / timing-error pulses.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-high
//   pix_en       one-clk pixel strobe
//   hsync_in     horizontal sync, active-low, asynchronous to clk
//   vsync_in     vertical sync, active-low, asynchronous to clk
//   hc, vc       hcnt - H_DAT_BEGIN, vcnt - V_DAT_BEGIN (modulo 1024)
//   effect       locked and inside the active window
//   locked       timing locked to the incoming syncs
//   frame_start  one-clk pulse when vcnt restarts while locked
//   sync_err     one-clk pulse on a timing violation in HLOCK/LOCKED
//   line_count   number of lines in the last completed frame
module vga_sync_decoder #(
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_DAT_BEGIN = 143,
    parameter int unsigned H_DAT_END   = 783,
    parameter int unsigned V_DAT_BEGIN = 34,
    parameter int unsigned V_DAT_END   = 514
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       effect,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_err,
    output logic [9:0] line_count
);

    localparam logic [9:0] HSync   = 10'(H_SYNC);
    localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
    localparam logic [9:0] HBegin  = 10'(H_DAT_BEGIN);
    localparam logic [9:0] HEnd    = 10'(H_DAT_END);
    localparam logic [9:0] VBegin  = 10'(V_DAT_BEGIN);
    localparam logic [9:0] VEnd    = 10'(V_DAT_END);
    localparam logic [9:0] CntMax  = 10'd1023;

    typedef enum logic [1:0] {StSearch, StHlock, StLocked} state_e;

    logic       hs_meta_q, hs_q, vs_meta_q, vs_q;
    logic       hs_prev_q, vs_prev_q;
    logic [9:0] hcnt_q, vcnt_q, hlow_q, hlow_cap_q, line_count_q;
    logic       vpend_q, seen_q;
    logic [1:0] good_q;
    state_e     state_q;
    logic       frame_start_q, sync_err_q;

    logic hfall, vfall, hrise, frame_line, line_eval, line_good, line_bad, hsat;

    // Edges are only meaningful between successive pixel strobes.
    assign hfall      = pix_en & hs_prev_q & ~hs_q;
    assign vfall      = pix_en & vs_prev_q & ~vs_q;
    assign hrise      = pix_en & ~hs_prev_q & hs_q;
    // A pending (or simultaneous) vsync is consumed by the next hsync.
    assign frame_line = hfall & (vpend_q | vfall);
    // The very first hfall has no preceding line to judge.
    assign line_eval  = hfall & seen_q;
    assign line_good  = (hcnt_q == HLast) && (hlow_cap_q == HSync);
    assign line_bad   = line_eval & ~line_good;
    // Counter about to saturate with no hsync in sight.
    assign hsat       = pix_en & ~hfall & (hcnt_q == CntMax - 10'd1);

    // Synchronizers and previous-strobe samples reset high: no false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_meta_q <= 1'b1;
            hs_q      <= 1'b1;
            vs_meta_q <= 1'b1;
            vs_q      <= 1'b1;
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
        end else begin
            hs_meta_q <= hsync_in;
            hs_q      <= hs_meta_q;
            vs_meta_q <= vsync_in;
            vs_q      <= vs_meta_q;
            if (pix_en) begin
                hs_prev_q <= hs_q;
                vs_prev_q <= vs_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            hlow_q       <= '0;
            hlow_cap_q   <= '0;
            line_count_q <= '0;
            vpend_q      <= 1'b0;
            seen_q       <= 1'b0;
        end else if (pix_en) begin
            if (hfall) begin
                hcnt_q <= '0;
            end else if (hcnt_q != CntMax) begin
                hcnt_q <= hcnt_q + 10'd1;
            end

            // hlow counts the hfall strobe itself, hence restart at 1.
            if (hfall) begin
                hlow_q <= 10'd1;
            end else if (!hs_q && hlow_q != CntMax) begin
                hlow_q <= hlow_q + 10'd1;
            end
            if (hrise) begin
                hlow_cap_q <= hlow_q;
            end

            if (hfall) begin
                seen_q <= 1'b1;
            end

            if (frame_line) begin
                vpend_q      <= 1'b0;
                vcnt_q       <= '0;
                line_count_q <= vcnt_q + 10'd1;
            end else begin
                if (vfall) begin
                    vpend_q <= 1'b1;
                end
                if (hfall && vcnt_q != CntMax) begin
                    vcnt_q <= vcnt_q + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StSearch;
            good_q        <= '0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
            if (pix_en) begin
                unique case (state_q)
                    StSearch: begin
                        if (line_eval) begin
                            if (!line_good) begin
                                good_q <= '0;
                            end else if (good_q == 2'd1) begin
                                good_q  <= '0;
                                state_q <= StHlock;
                            end else begin
                                good_q <= good_q + 2'd1;
                            end
                        end
                    end
                    StHlock: begin
                        if (line_bad) begin
                            sync_err_q <= 1'b1;
                            state_q    <= StSearch;
                        end else if (frame_line) begin
                            frame_start_q <= 1'b1;
                            state_q       <= StLocked;
                        end
                    end
                    StLocked: begin
                        if (line_bad || hsat) begin
                            sync_err_q <= 1'b1;
                            state_q    <= StSearch;
                        end else if (frame_line) begin
                            frame_start_q <= 1'b1;
                        end
                    end
                    default: state_q <= StSearch;
                endcase
            end
        end
    end

    assign locked      = (state_q == StLocked);
    assign frame_start = frame_start_q;
    assign sync_err    = sync_err_q;
    assign line_count  = line_count_q;
    assign hc          = hcnt_q - HBegin;
    assign vc          = vcnt_q - VBegin;
    assign effect      = locked && (hcnt_q >= HBegin) && (hcnt_q < HEnd) &&
                         (vcnt_q >= VBegin) && (vcnt_q < VEnd);

endmodule

// File: tb/tb_vga_sync_decoder.sv
`timescale 1ns / 1ps
// Testbench for vga_sync_decoder. A scaled-down raster (40 pixels x 12 lines,
// hsync low 8) keeps runs short; a second instance with default parameters
// covers the full-size reset offsets.
module tb_vga_sync_decoder;

    localparam int unsigned TH_SYNC  = 8;
    localparam int unsigned TH_TOTAL = 40;
    localparam int unsigned TH_BEG   = 12;
    localparam int unsigned TH_END   = 36;
    localparam int unsigned TV_BEG   = 3;
    localparam int unsigned TV_END   = 10;
    localparam int          V_LINES  = 12;

    localparam int MPLAIN    = 0;
    localparam int MNOM      = 1;
    localparam int MLONG     = 2;
    localparam int MSHORT    = 3;
    localparam int MVMID     = 4;
    localparam int MRESET    = 5;
    localparam int MPOSTVMID = 6;
    localparam int MPOSTRST  = 7;

    logic       clk = 1'b0;
    logic       reset, pix_en, hsync_in, vsync_in;
    logic [9:0] hc, vc, line_count;
    logic       effect, locked, frame_start, sync_err;
    logic [9:0] hc_d, vc_d, line_count_d;
    logic       effect_d, locked_d, frame_start_d, sync_err_d;

    int n_cmp = 0;
    int n_err = 0;
    int fs_cnt = 0;
    int se_cnt = 0;
    int gen_v, gen_h;

    vga_sync_decoder #(
        .H_SYNC      (TH_SYNC),
        .H_TOTAL     (TH_TOTAL),
        .H_DAT_BEGIN (TH_BEG),
        .H_DAT_END   (TH_END),
        .V_DAT_BEGIN (TV_BEG),
        .V_DAT_END   (TV_END)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .hc          (hc),
        .vc          (vc),
        .effect      (effect),
        .locked      (locked),
        .frame_start (frame_start),
        .sync_err    (sync_err),
        .line_count  (line_count)
    );

    vga_sync_decoder u_dut_def (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .hc          (hc_d),
        .vc          (vc_d),
        .effect      (effect_d),
        .locked      (locked_d),
        .frame_start (frame_start_d),
        .sync_err    (sync_err_d),
        .line_count  (line_count_d)
    );

    always #5 clk = ~clk;

    // Count high clocks of each pulse; a pulse wider than one clk inflates the count.
    always @(negedge clk) begin
        if (frame_start === 1'b1) fs_cnt++;
        if (sync_err === 1'b1) se_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (line %0d px %0d)", tag, got, exp,
                     gen_v, gen_h);
        end
    endtask

    // One pixel: inputs settle, then a strobe on the 4th clk; returns on the
    // negedge after the strobe edge.
    task automatic px(input logic hs, input logic vs);
        hsync_in = hs;
        vsync_in = vs;
        pix_en   = 1'b0;
        repeat (3) @(negedge clk);
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    task automatic probe(input int mode);
        case (mode)
            MNOM: begin
                if (gen_v == 0 && gen_h == 0) begin
                    check("nom_locked", locked, 1);
                    check("nom_fs", frame_start, 1);
                    check("nom_vc_frame", vc, 1021);
                    check("nom_line_count", line_count, 12);
                end
                if (gen_v == 0 && gen_h == 1) check("nom_fs_width", frame_start, 0);
                if (gen_v == 3 && gen_h == 12) begin
                    check("nom_hc_origin", hc, 0);
                    check("nom_vc_origin", vc, 0);
                    check("nom_effect_origin", effect, 1);
                end
                if (gen_v == 3 && gen_h == 11) check("nom_effect_hpre", effect, 0);
                if (gen_v == 3 && gen_h == 35) check("nom_effect_hlast", effect, 1);
                if (gen_v == 3 && gen_h == 36) check("nom_effect_hend", effect, 0);
                if (gen_v == 2 && gen_h == 20) check("nom_effect_vpre", effect, 0);
                if (gen_v == 9 && gen_h == 20) check("nom_effect_vlast", effect, 1);
                if (gen_v == 10 && gen_h == 20) check("nom_effect_vend", effect, 0);
                if (gen_v == 5 && gen_h == 0) begin
                    check("nom_hc_wrap", hc, 1012);
                    check("nom_vc_line5", vc, 2);
                end
            end
            MLONG: begin
                if (gen_v == 5 && gen_h == 40) check("long_hc_extra", hc, 28);
                if (gen_v == 6 && gen_h == 0) begin
                    check("long_sync_err", sync_err, 1);
                    check("long_locked", locked, 0);
                end
                if (gen_v == 6 && gen_h == 1) check("long_err_width", sync_err, 0);
                if (gen_v == 6 && gen_h == 20) check("long_effect", effect, 0);
            end
            MSHORT: begin
                if (gen_v == 6 && gen_h == 0) begin
                    check("short_sync_err", sync_err, 1);
                    check("short_locked", locked, 0);
                end
                if (gen_v == 7 && gen_h == 0) check("short_still_unlocked", locked, 0);
            end
            MVMID: begin
                if (gen_v == 0 && gen_h == 25) begin
                    check("vmid_vc_hold", vc, 9);
                    check("vmid_no_fs", frame_start, 0);
                    check("vmid_locked", locked, 1);
                end
                if (gen_v == 1 && gen_h == 0) begin
                    check("vmid_fs", frame_start, 1);
                    check("vmid_vc_zero", vc, 1021);
                    check("vmid_line_count", line_count, 13);
                end
                if (gen_v == 1 && gen_h == 1) check("vmid_fs_width", frame_start, 0);
            end
            MPOSTVMID: begin
                if (gen_v == 0 && gen_h == 0) begin
                    check("pvmid_line_count", line_count, 11);
                    check("pvmid_fs", frame_start, 1);
                end
            end
            MRESET: begin
                if (gen_v == 6 && gen_h == 20) begin
                    check("rst_effect_before", effect, 1);
                    reset = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                    check("rst_locked", locked, 0);
                    check("rst_effect", effect, 0);
                    check("rst_fs", frame_start, 0);
                    check("rst_sync_err", sync_err, 0);
                    check("rst_line_count", line_count, 0);
                    check("rst_hc", hc, 1012);
                    check("rst_vc", vc, 1021);
                end
            end
            MPOSTRST: begin
                if (gen_v == 0 && gen_h == 0) begin
                    check("prst_line_count", line_count, 6);
                    check("prst_locked", locked, 1);
                    check("prst_fs", frame_start, 1);
                end
            end
            default: ;
        endcase
    endtask

    // Vsync low on lines 0-1 from the hsync falling edge, except in MVMID
    // where it falls mid-line 0.
    task automatic frame(input int mode);
        int   len;
        int   low;
        logic vsl;
        for (int v = 0; v < V_LINES; v++) begin
            len = (mode == MLONG && v == 5) ? int'(TH_TOTAL) + 1 : int'(TH_TOTAL);
            low = (mode == MSHORT && v == 5) ? int'(TH_SYNC) - 1 : int'(TH_SYNC);
            for (int h = 0; h < len; h++) begin
                if (mode == MVMID) vsl = (v == 0 && h >= 20) || (v == 1);
                else vsl = (v < 2);
                gen_v = v;
                gen_h = h;
                px((h >= low) ? 1'b1 : 1'b0, ~vsl);
                probe(mode);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        pix_en   = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        gen_v    = -1;
        gen_h    = -1;
        repeat (3) @(negedge clk);
        check("reset_locked", locked, 0);
        check("reset_effect", effect, 0);
        check("reset_fs", frame_start, 0);
        check("reset_sync_err", sync_err, 0);
        check("reset_line_count", line_count, 0);
        check("reset_hc", hc, 1012);
        check("reset_vc", vc, 1021);
        check("reset_hc_default", hc_d, 881);
        check("reset_vc_default", vc_d, 990);
        check("reset_flags_default", {locked_d, effect_d, frame_start_d, sync_err_d}, 0);
        check("reset_lc_default", line_count_d, 0);
        reset = 1'b0;

        frame(MPLAIN);
        check("f1_hlock_not_locked", locked, 0);
        check("f1_line_count", line_count, 1);
        check("f1_fs_cnt", fs_cnt, 0);
        frame(MNOM);
        frame(MPLAIN);
        check("f3_line_count", line_count, 12);
        check("f3_fs_cnt", fs_cnt, 2);
        check("f3_se_cnt", se_cnt, 0);
        check("f3_locked", locked, 1);

        frame(MLONG);
        check("f4_locked", locked, 0);
        check("f4_se_cnt", se_cnt, 1);
        frame(MPLAIN);
        check("f5_relocked", locked, 1);
        check("f5_fs_cnt", fs_cnt, 4);

        frame(MSHORT);
        check("f6_se_cnt", se_cnt, 2);
        check("f6_locked", locked, 0);
        frame(MPLAIN);
        check("f7_relocked", locked, 1);
        check("f7_fs_cnt", fs_cnt, 6);

        gen_v = -2;
        for (int i = 0; i < 900; i++) px(1'b1, 1'b1);
        check("miss_still_locked", locked, 1);
        check("miss_no_err_yet", se_cnt, 2);
        for (int i = 0; i < 200; i++) px(1'b1, 1'b1);
        check("miss_locked", locked, 0);
        check("miss_se_cnt", se_cnt, 3);
        check("miss_hc_sat", hc, 1011);
        for (int i = 0; i < 100; i++) px(1'b1, 1'b1);
        check("miss_se_once", se_cnt, 3);
        check("miss_stays_unlocked", locked, 0);

        frame(MPLAIN);
        check("f8_not_locked", locked, 0);
        check("f8_fs_cnt", fs_cnt, 6);
        frame(MPLAIN);
        check("f9_locked", locked, 1);
        check("f9_fs_cnt", fs_cnt, 7);

        frame(MVMID);
        check("f10_fs_cnt", fs_cnt, 8);
        frame(MPOSTVMID);
        check("f11_fs_cnt", fs_cnt, 9);

        frame(MRESET);
        check("f12_not_locked", locked, 0);
        check("f12_fs_cnt", fs_cnt, 10);
        check("f12_se_cnt", se_cnt, 3);
        frame(MPOSTRST);
        check("f13_locked", locked, 1);
        check("f13_fs_cnt", fs_cnt, 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA timing generator. Takes `hsync`/`vsync` and a pixel strobe, and recovers the following:

- pixel coordinates within the 640x480 active area
- an active-video flag
- lock status
- per-frame line count
- frame-start and timing-error pulses

Used as a loopback checker on the generator's outputs and as the front end of the frame-capture path. Runs in the system clock domain with a pixel-enable.

## Interface
- `H_SYNC`, 96: expected `hsync` low width, pixels
- `H_TOTAL`, 800: expected pixels per line
- `H_DAT_BEGIN`, 143: first active pixel index, counted from the `hsync` falling edge (index 0)
- `H_DAT_END`, 783: first inactive pixel index after active region
- `V_DAT_BEGIN`, 34: first active line index, counted from the frame line (index 0)
- `V_DAT_END`, 514: first inactive line index after active region
- `clk`  in  1  system clock; one clock domain, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `pix_en`  in  1  pixel strobe, one `clk` wide; nominally every 4th `clk`
- `hsync_in`  in  1  horizontal sync, active-low, asynchronous to `clk`
- `vsync_in`  in  1  vertical sync, active-low, asynchronous to `clk`
- `hc`  out  10  hcnt − `H_DAT_BEGIN`, modulo 1024
- `vc`  out  10  vcnt − `V_DAT_BEGIN`, modulo 1024
- `effect`  out  1  high when locked and hcnt/vcnt are inside the active window
- `locked`  out  1  high in LOCKED state
- `frame_start`  out  1  one-`clk` pulse when vcnt is set to 0 while LOCKED
- `sync_err`  out  1  one-`clk` pulse on a timing violation while in HLOCK or LOCKED
- `line_count`  out  10  number of lines in the last completed frame

## Operation
**Input sampling**
- `hsync_in` and `vsync_in` each pass through a 2-flop synchronizer on every `clk`.
- Edge detection compares the synchronized values at successive `pix_en` strobes only.
- `hfall`: the previous strobe's `hs` was 1 and the current `hs` is 0. `vfall` is defined the same way for `vs`.

**Counters** (all update only on `pix_en`)
- hcnt, 10 bits:
  - `hfall` sets hcnt to 0.
  - Otherwise hcnt increments, saturating at 1023.
- hlow, 10 bits:
  - Counts strobes with `hs`=0, including the `hfall` strobe.
  - Cleared at `hfall`.
  - Its value is captured at the first strobe where `hs` returns to 1.
- vpend flag:
  - `vfall` sets vpend.
  - The next `hfall` (or the same strobe, if simultaneous) clears vpend, sets vcnt to 0, latches vcnt+1 into `line_count`, and counts as a frame line.
- vcnt, 10 bits:
  - Any other `hfall` increments vcnt, saturating at 1023.

**Line check** at each `hfall` after the first:
- The line is good when hcnt == `H_TOTAL`−1 and the captured hlow == `H_SYNC`.

**State machine**
- SEARCH (reset state):
  - Goes to HLOCK after 2 consecutive good lines.
  - A bad line restarts the good-line count.
- HLOCK:
  - A bad line: `sync_err` pulse, go to SEARCH.
  - A frame line (vpend consumed at `hfall`): go to LOCKED and pulse `frame_start`.
- LOCKED:
  - A bad line: `sync_err` pulse, go to SEARCH, `locked` drops next `clk`.
  - hcnt reaching 1023 without an `hfall` counts as a bad line.
  - Every frame line pulses `frame_start`.
- Outside LOCKED, the counters still run and `line_count` still updates, but `effect` is forced to 0.

**Active window**
- `effect` = locked && `H_DAT_BEGIN` ≤ hcnt < `H_DAT_END` && `V_DAT_BEGIN` ≤ vcnt < `V_DAT_END`.

## Timing
**Reset values**
- hcnt, vcnt, hlow, good-line count: 0.
- vpend, all pulses, `locked`, `effect`: 0.
- `line_count`: 0. State: SEARCH.
- Synchronizer flops and the previous-sample registers reset to 1, so there is no false edge after reset.

**Reset mid-operation**
- Everything returns to the reset values on the next `clk`.
- Relock requires 2 good lines plus a frame line.

**Latency and output alignment**
- From a `hsync_in` change to its use: 2 `clk` synchronizer latency plus wait for the next `pix_en`.
- hcnt/vcnt register on the `pix_en` `clk` edge.
- `hc`, `vc`, `effect` are combinational from the registers and valid the same cycle.
- `frame_start` and `sync_err` are registered: they assert the `clk` after the deciding strobe and last exactly one `clk`.
- `hc`/`vc` wrap modulo 1024 outside the active window.
  - Example: hcnt=0 gives `hc`=881.

## Test plan
- **Nominal lock:** 800x525 frames (`hsync` low 96, `vsync` low lines 0-1, `pix_en` every 4 `clk`) → `locked`=1 at the first frame line after 2 good lines.
  - At hcnt=143, vcnt=34: `hc`=0, `vc`=0, `effect`=1.
  - At hcnt=783: `effect`=0.
  - `line_count`=525 after the second locked frame.
- **Long line:** lengthen one line to 801 pixels → a single `sync_err` pulse, `locked` falls, `effect`=0; relock occurs at the next frame line after 2 good lines.
- **Sync width:** set `hsync` low width to 95 on one line → `sync_err`, state returns to SEARCH.
- **Missing sync:** hold `hsync_in` high → hcnt saturates at 1023, `sync_err` once, `locked`=0 and stays 0.
- **Vsync placement:** `vsync` falls mid-line (hcnt=400) → vcnt is unchanged until the next `hfall`, which sets vcnt=0 and pulses `frame_start` once. `vsync` falling on the same strobe as `hsync` → vcnt=0 on that strobe.
- **Reset mid-frame:** assert `reset` for 1 `clk` at vcnt=200 → all outputs 0 the next `clk`; relock follows the nominal sequence.
